fetch_unit: RTL and testbench

- Pipelined fetch stage (IF) of the LEGv8 pipeline, directly upstream of decode.
- Owns the PC and issues word fetches to instruction memory through a req/gnt/rvalid handshake, at most one request outstanding.
- Buffers returned instructions in a small FIFO that feeds decode through the IF/ID valid/stall interface.
- Handles branch redirects from MEM: flushes the buffer and discards any in-flight response.

---
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time over a
// req/gnt/rvalid handshake, and buffers returned instructions in a small FIFO
// that feeds decode. A taken branch from MEM flushes the buffer and squashes
// any fetch still in flight.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no request outstanding; may issue when the FIFO has room
// WAIT   | one request accepted, response pending, data will be kept
// DROP   | one request accepted, but squashed by a redirect; data dropped
module fetch_unit #(
  parameter int             N        = 64,
  parameter logic [N-1:0]   RESET_PC = '0,
  parameter int             DEPTH    = 2
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [N-1:0]  imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  input  logic          stall_D,
  input  logic          pcsrc_M,
  input  logic [N-1:0]  pcbranch_M,
  output logic          valid_D,
  output logic [31:0]   instr_D,
  output logic [N-1:0]  pc_D
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  pc_q;
  logic [N-1:0]  req_pc_q;
  logic [31:0]   fifo_instr [DEPTH];
  logic [N-1:0]  fifo_pc    [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          issue, push, pop, empty;
  logic          unused_branch_lsb;

  // Branch targets are forced word aligned, so the low bits never matter.
  assign unused_branch_lsb = ^pcbranch_M[1:0];

  assign empty = (count_q == '0);

  // Credit uses the registered count, so a pop only frees a slot next cycle.
  // The reset term keeps the request low while reset is held.
  assign imem_req  = reset && (state_q == S_IDLE) && (count_q < DEPTH_C) && !pcsrc_M;
  assign imem_addr = pc_q;
  assign issue     = imem_req && imem_gnt;

  // A redirect wins over everything: response data and decode pops are ignored.
  assign push = (state_q == S_WAIT) && imem_rvalid && !pcsrc_M;
  assign pop  = !empty && !stall_D && !pcsrc_M;

  assign valid_D = !empty;
  assign instr_D = empty ? '0 : fifo_instr[rd_ptr_q];
  assign pc_D    = empty ? '0 : fifo_pc[rd_ptr_q];

  // Next-state logic; a response always closes out the outstanding request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (issue) state_d = S_WAIT;
      S_WAIT:  if (imem_rvalid) state_d = S_IDLE;
               else if (pcsrc_M) state_d = S_DROP;
      S_DROP:  if (imem_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // PC: redirect loads the aligned target, an accepted request steps by one word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      if (pcsrc_M)    pc_q <= {pcbranch_M[N-1:2], 2'b00};
      else if (issue) pc_q <= pc_q + N'(4);
      if (issue) req_pc_q <= pc_q;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (pcsrc_M) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; credit guarantees a push never lands on a full buffer.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr_q] <= imem_rdata;
      fifo_pc[wr_ptr_q]    <= req_pc_q;
    end
  end

  // A response with no request outstanding means the memory side broke the handshake.
  assert property (@(posedge clk) disable iff (!reset) !(imem_rvalid && state_q == S_IDLE));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a long randomized run, all
// compared against a queue-based reference of the fetch stream.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_D;
  logic        pcsrc_M;
  logic [63:0] pcbranch_M;
  logic        valid_D;
  logic [31:0] instr_D;
  logic [63:0] pc_D;

  int checks = 0;
  int failures = 0;

  // reference model: next fetch address, buffered addresses, in-flight request
  logic [63:0] m_pc;
  logic [63:0] m_pend_pc;
  bit          m_pend;
  bit          m_squash;
  logic [63:0] m_q[$];

  // memory environment
  bit          env_busy;
  int          env_wait;
  logic [63:0] env_addr;
  int          lat_fix;

  // values applied this cycle and the expectations derived from the model
  bit          a_st, a_rd, a_g;
  logic [63:0] a_tgt;
  bit          e_req;
  logic [63:0] e_addr;
  bit          e_valid;
  logic [63:0] e_pc;
  logic [31:0] e_instr;

  fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall_D(stall_D), .pcsrc_M(pcsrc_M), .pcbranch_M(pcbranch_M),
    .valid_D(valid_D), .instr_D(instr_D), .pc_D(pc_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_1234;
  endfunction

  task automatic hold_reset();
    reset = 1'b0;
    stall_D = 1'b0; pcsrc_M = 1'b0; pcbranch_M = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    env_busy = 1'b0; env_wait = 0; env_addr = '0; lat_fix = 0;
    m_pc = 64'h0; m_pend_pc = '0; m_pend = 1'b0; m_squash = 1'b0; m_q.delete();
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic do_reset();
    hold_reset();
    release_reset();
  endtask

  // Drive one cycle of inputs (at posedge+1) and derive expectations; returns at posedge+4.
  task automatic apply(input bit st, input bit rd, input logic [63:0] tgt, input bit g);
    a_st = st; a_rd = rd; a_tgt = tgt; a_g = g;
    stall_D = st; pcsrc_M = rd; pcbranch_M = tgt; imem_gnt = g;
    imem_rvalid = env_busy && (env_wait == 0);
    imem_rdata  = imem_rvalid ? mem_word(env_addr) : 32'($urandom());
    e_req   = !m_pend && (m_q.size() < DEPTH) && !rd;
    e_addr  = m_pc;
    e_valid = (m_q.size() > 0);
    e_pc    = e_valid ? m_q[0] : 64'h0;
    e_instr = e_valid ? mem_word(m_q[0]) : 32'h0;
    #3;
  endtask

  // Commit the cycle at the rising edge: memory environment and reference model.
  task automatic advance();
    bit          acc;
    bit          rv;
    logic [63:0] acc_addr;
    acc = imem_req && imem_gnt;
    acc_addr = imem_addr;
    rv = imem_rvalid;
    @(posedge clk);
    if (rv) env_busy = 1'b0;
    else if (env_busy) env_wait--;
    if (acc) begin
      env_busy = 1'b1;
      env_addr = acc_addr;
      env_wait = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
    end
    if (a_rd) begin
      m_q.delete();
      m_pc = {a_tgt[63:2], 2'b00};
      if (m_pend) begin
        if (rv) begin m_pend = 1'b0; m_squash = 1'b0; end
        else m_squash = 1'b1;
      end
    end else begin
      if (m_q.size() > 0 && !a_st) void'(m_q.pop_front());
      if (m_pend && rv) begin
        if (!m_squash) m_q.push_back(m_pend_pc);
        m_pend = 1'b0; m_squash = 1'b0;
      end
      if (e_req && a_g) begin
        m_pend = 1'b1; m_pend_pc = m_pc; m_pc = m_pc + 64'd4;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    hold_reset();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (valid_D !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_D); end
    checks++; if (instr_D !== 32'h0 || pc_D !== 64'h0) begin failures++; $display("FAIL reset_head got=%h/%h exp=0/0", instr_D, pc_D); end
    checks++; if (imem_addr !== 64'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", imem_addr); end
    release_reset();
  endtask

  task automatic test_stream();
    logic [63:0] seen[$];
    int reqs = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      apply(1'b0, 1'b0, 64'h0, 1'b1);
      checks++; if (imem_req !== e_req) begin failures++; $display("FAIL stream_req c=%0d got=%b exp=%b", c, imem_req, e_req); end
      if (e_req) begin checks++; if (imem_addr !== e_addr) begin failures++; $display("FAIL stream_addr c=%0d got=%h exp=%h", c, imem_addr, e_addr); end end
      checks++; if (valid_D !== e_valid) begin failures++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, valid_D, e_valid); end
      checks++; if (pc_D !== e_pc || instr_D !== e_instr) begin failures++; $display("FAIL stream_head c=%0d got=%h/%h exp=%h/%h", c, pc_D, instr_D, e_pc, e_instr); end
      if (valid_D) seen.push_back(pc_D);
      if (imem_req) reqs++;
      advance();
    end
    checks++;
    if (seen.size() < 3) begin failures++; $display("FAIL stream_count got=%0d exp>=3", seen.size()); end
    else if (seen[0] !== 64'h0 || seen[1] !== 64'h4 || seen[2] !== 64'h8) begin
      failures++; $display("FAIL stream_order got=%h,%h,%h exp=0,4,8", seen[0], seen[1], seen[2]);
    end
    checks++; if (reqs !== 5) begin failures++; $display("FAIL stream_rate got=%0d exp=5", reqs); end
  endtask

  task automatic test_stall_fill();
    logic [63:0] pops[$];
    logic [63:0] first_addr = 64'hDEAD;
    bit got = 1'b0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      apply(1'b1, 1'b0, 64'h0, 1'b1);
      checks++; if (imem_req !== e_req) begin failures++; $display("FAIL fill_req c=%0d got=%b exp=%b", c, imem_req, e_req); end
      checks++; if (valid_D !== e_valid || pc_D !== e_pc) begin failures++; $display("FAIL fill_head c=%0d got=%b/%h exp=%b/%h", c, valid_D, pc_D, e_valid, e_pc); end
      advance();
    end
    apply(1'b1, 1'b0, 64'h0, 1'b1);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL full_req got=%b exp=0", imem_req); end
    checks++; if (valid_D !== 1'b1 || pc_D !== 64'h0 || instr_D !== mem_word(64'h0)) begin failures++; $display("FAIL full_head got=%b/%h/%h exp=1/0/%h", valid_D, pc_D, instr_D, mem_word(64'h0)); end
    advance();
    for (int c = 0; c < 8; c++) begin
      apply(1'b0, 1'b0, 64'h0, 1'b1);
      checks++; if (imem_req !== e_req) begin failures++; $display("FAIL drain_req c=%0d got=%b exp=%b", c, imem_req, e_req); end
      checks++; if (valid_D !== e_valid || pc_D !== e_pc || instr_D !== e_instr) begin failures++; $display("FAIL drain_head c=%0d got=%b/%h exp=%b/%h", c, valid_D, pc_D, e_valid, e_pc); end
      if (valid_D) pops.push_back(pc_D);
      if (imem_req && !got) begin got = 1'b1; first_addr = imem_addr; end
      advance();
    end
    checks++;
    if (pops.size() < 2) begin failures++; $display("FAIL drain_count got=%0d exp>=2", pops.size()); end
    else if (pops[0] !== 64'h0 || pops[1] !== 64'h4) begin failures++; $display("FAIL drain_order got=%h,%h exp=0,4", pops[0], pops[1]); end
    checks++; if (first_addr !== 64'h8) begin failures++; $display("FAIL resume_addr got=%h exp=8", first_addr); end
  endtask

  task automatic test_gnt_hold();
    bit found = 1'b0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      apply(1'b0, 1'b0, 64'h0, (c == 3));
      checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin failures++; $display("FAIL hold_addr c=%0d got=%b/%h exp=1/0", c, imem_req, imem_addr); end
      advance();
    end
    for (int c = 0; c < 6 && !found; c++) begin
      apply(1'b0, 1'b0, 64'h0, 1'b1);
      if (imem_req) begin
        found = 1'b1;
        checks++; if (imem_addr !== 64'h4) begin failures++; $display("FAIL hold_next got=%h exp=4", imem_addr); end
      end
      advance();
    end
    if (!found) begin checks++; failures++; $display("FAIL hold_timeout got=no_req exp=req"); end
  endtask

  task automatic test_redirect_wait();
    bit got_req = 1'b0;
    bit shown = 1'b0;
    do_reset();
    apply(1'b1, 1'b0, 64'h0, 1'b1); advance();
    apply(1'b1, 1'b0, 64'h0, 1'b1); advance();
    lat_fix = 2;
    apply(1'b1, 1'b0, 64'h0, 1'b1);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h4) begin failures++; $display("FAIL rw_issue got=%b/%h exp=1/4", imem_req, imem_addr); end
    advance();
    lat_fix = 0;
    apply(1'b0, 1'b1, 64'h100, 1'b1);
    checks++; if (imem_req !== 1'b0 || valid_D !== 1'b1) begin failures++; $display("FAIL rw_redirect got=%b/%b exp=0/1", imem_req, valid_D); end
    advance();
    for (int c = 0; c < 12; c++) begin
      apply(1'b0, 1'b0, 64'h0, 1'b1);
      checks++; if (imem_req !== e_req) begin failures++; $display("FAIL rw_req c=%0d got=%b exp=%b", c, imem_req, e_req); end
      checks++; if (valid_D !== e_valid || pc_D !== e_pc || instr_D !== e_instr) begin failures++; $display("FAIL rw_head c=%0d got=%b/%h exp=%b/%h", c, valid_D, pc_D, e_valid, e_pc); end
      if (imem_req && !got_req) begin
        got_req = 1'b1;
        checks++; if (imem_addr !== 64'h100) begin failures++; $display("FAIL rw_target got=%h exp=100", imem_addr); end
      end
      if (valid_D && !shown) begin
        shown = 1'b1;
        checks++; if (pc_D !== 64'h100) begin failures++; $display("FAIL rw_first got=%h exp=100", pc_D); end
      end
      advance();
    end
    if (!got_req || !shown) begin checks++; failures++; $display("FAIL rw_timeout got=%b/%b exp=1/1", got_req, shown); end
  endtask

  task automatic test_redirect_coincident();
    do_reset();
    apply(1'b1, 1'b0, 64'h0, 1'b1); advance();
    apply(1'b1, 1'b0, 64'h0, 1'b1); advance();
    apply(1'b1, 1'b0, 64'h0, 1'b1); advance();
    apply(1'b0, 1'b1, 64'h203, 1'b1);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rc_req got=%b exp=0", imem_req); end
    checks++; if (valid_D !== 1'b1 || pc_D !== 64'h0) begin failures++; $display("FAIL rc_head got=%b/%h exp=1/0", valid_D, pc_D); end
    advance();
    apply(1'b0, 1'b0, 64'h0, 1'b1);
    checks++; if (valid_D !== 1'b0) begin failures++; $display("FAIL rc_flush got=%b exp=0", valid_D); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h200) begin failures++; $display("FAIL rc_target got=%b/%h exp=1/200", imem_req, imem_addr); end
    advance();
    for (int c = 0; c < 4; c++) begin
      apply(1'b0, 1'b0, 64'h0, 1'b1);
      checks++; if (valid_D !== e_valid || pc_D !== e_pc || instr_D !== e_instr) begin failures++; $display("FAIL rc_after c=%0d got=%b/%h exp=%b/%h", c, valid_D, pc_D, e_valid, e_pc); end
      advance();
    end
  endtask

  task automatic test_reset_midwait();
    do_reset();
    apply(1'b1, 1'b0, 64'h0, 1'b1); advance();
    apply(1'b1, 1'b0, 64'h0, 1'b1); advance();
    lat_fix = 2;
    apply(1'b1, 1'b0, 64'h0, 1'b1); advance();
    apply(1'b1, 1'b0, 64'h0, 1'b0);
    checks++; if (valid_D !== 1'b1 || pc_D !== 64'h0) begin failures++; $display("FAIL mw_pre got=%b/%h exp=1/0", valid_D, pc_D); end
    hold_reset();
    checks++; if (imem_req !== 1'b0 || valid_D !== 1'b0) begin failures++; $display("FAIL mw_async got=%b/%b exp=0/0", imem_req, valid_D); end
    checks++; if (instr_D !== 32'h0 || pc_D !== 64'h0) begin failures++; $display("FAIL mw_head got=%h/%h exp=0/0", instr_D, pc_D); end
    release_reset();
    apply(1'b0, 1'b0, 64'h0, 1'b1);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin failures++; $display("FAIL mw_restart got=%b/%h exp=1/0", imem_req, imem_addr); end
    advance();
    for (int c = 0; c < 4; c++) begin
      apply(1'b0, 1'b0, 64'h0, 1'b1);
      checks++; if (valid_D !== e_valid || pc_D !== e_pc || instr_D !== e_instr) begin failures++; $display("FAIL mw_after c=%0d got=%b/%h exp=%b/%h", c, valid_D, pc_D, e_valid, e_pc); end
      advance();
    end
  endtask

  task automatic test_random();
    bit          st, rd, g;
    logic [63:0] tgt;
    do_reset();
    lat_fix = -1;
    for (int c = 0; c < 2500; c++) begin
      st = ($urandom_range(0, 99) < 30);
      rd = ($urandom_range(0, 99) < 4);
      g  = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      else tgt = {32'($urandom), 32'($urandom)};
      apply(st, rd, tgt, g);
      checks++; if (imem_req !== e_req) begin failures++; $display("FAIL rnd_req c=%0d got=%b exp=%b", c, imem_req, e_req); end
      if (e_req) begin checks++; if (imem_addr !== e_addr) begin failures++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, imem_addr, e_addr); end end
      checks++; if (valid_D !== e_valid) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, valid_D, e_valid); end
      checks++; if (pc_D !== e_pc || instr_D !== e_instr) begin failures++; $display("FAIL rnd_head c=%0d got=%h/%h exp=%h/%h", c, pc_D, instr_D, e_pc, e_instr); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_fill();
    test_gnt_hold();
    test_redirect_wait();
    test_redirect_coincident();
    test_reset_midwait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
